data_read_axi_master: RTL and testbench

//  AXI4-Lite master (initiator) issuing single read/write transactions from a simple command port.

---
 rtl/data_read_axi_pkg.sv | 31 +++
 rtl/data_read_axi_master_wdog.sv | 53 +++++
 rtl/data_read_axi_master.sv | 190 +++++++++++++++++++
 tb/tb_data_read_axi_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_read_axi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : data_read_axi_pkg
// Purpose  : FSM encodings, AXI response codes and helpers shared by the
//            data_read AXI4-Lite master and slave.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package data_read_axi_pkg;

   typedef logic [2:0] axi_state_t;
   typedef logic [1:0] axi_resp_t;

   localparam axi_state_t ST_IDLE    = 3'd0;
   localparam axi_state_t ST_WR_REQ  = 3'd1;
   localparam axi_state_t ST_WR_RESP = 3'd2;
   localparam axi_state_t ST_RD_REQ  = 3'd3;
   localparam axi_state_t ST_RD_DATA = 3'd4;
   localparam axi_state_t ST_RSP     = 3'd5;

   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_EXOKAY = 2'b01;
   localparam axi_resp_t RESP_SLVERR = 2'b10;
   localparam axi_resp_t RESP_DECERR = 2'b11;

   // States in which the master is waiting on the slave.
   function automatic logic is_wait_state(input axi_state_t state);
      return (state != ST_IDLE) && (state != ST_RSP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_read_axi_master_wdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : data_read_axi_master_wdog
// Purpose  : Counts cycles spent in one master state and raises a sticky flag
//            when a slave-wait state lasts TIMEOUT cycles.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module data_read_axi_master_wdog
   import data_read_axi_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
)(
   input  logic       clk,
   input  logic       rst,
   input  axi_state_t i_state,
   output logic       o_timeout
);

   localparam int unsigned             c_CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0]      c_SAT   = c_CNT_W'(TIMEOUT);
   localparam logic [c_CNT_W-1:0]      c_LAST  = c_CNT_W'(TIMEOUT - 1);
   localparam logic [c_CNT_W-1:0]      c_ONE   = c_CNT_W'(1);

   axi_state_t         r_prev_state;
   logic [c_CNT_W-1:0] r_count;
   logic [c_CNT_W-1:0] w_count_cur;
   logic               r_timeout;

   // A state change restarts the count within the same cycle it is seen.
   assign w_count_cur = (i_state != r_prev_state) ? '0 : r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev_state <= ST_IDLE;
         r_count      <= '0;
         r_timeout    <= 1'b0;
      end else begin
         r_prev_state <= i_state;
         if (w_count_cur != c_SAT) begin
            r_count <= w_count_cur + c_ONE;
         end else begin
            r_count <= w_count_cur;
         end
         if (is_wait_state(i_state) && (w_count_cur == c_LAST)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/data_read_axi_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : data_read_axi_master
// Purpose  : AXI4-Lite master issuing one read or write per command, with the
//            result returned on a valid/ready response port.
//            Optional watchdog: define DATA_READ_AXI_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module data_read_axi_master
   import data_read_axi_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 1024
)(
   input  logic                M_AXI_ACLK,
   input  logic                M_AXI_ARESET,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic [ADDR_W-1:0]   M_AXI_AWADDR,
   output logic                M_AXI_AWVALID,
   input  logic                M_AXI_AWREADY,
   output logic [DATA_W-1:0]   M_AXI_WDATA,
   output logic [DATA_W/8-1:0] M_AXI_WSTRB,
   output logic                M_AXI_WVALID,
   input  logic                M_AXI_WREADY,
   input  logic [1:0]          M_AXI_BRESP,
   input  logic                M_AXI_BVALID,
   output logic                M_AXI_BREADY,
   output logic [ADDR_W-1:0]   M_AXI_ARADDR,
   output logic                M_AXI_ARVALID,
   input  logic                M_AXI_ARREADY,
   input  logic [DATA_W-1:0]   M_AXI_RDATA,
   input  logic [1:0]          M_AXI_RRESP,
   input  logic                M_AXI_RVALID,
   output logic                M_AXI_RREADY,
   output logic                timeout_err
);

   axi_state_t          r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W/8-1:0] r_wstrb;
   logic                r_awvalid;
   logic                r_wvalid;
   logic                r_bready;
   logic                r_arvalid;
   logic                r_rready;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_rdata;
   axi_resp_t           r_rsp_resp;

   logic w_aw_hs;
   logic w_w_hs;
   logic w_aw_fin;
   logic w_w_fin;
   logic w_timeout;

   if (TIMEOUT < 1) begin : g_timeout_range
      $error("data_read_axi_master: TIMEOUT must be at least 1");
   end

   assign w_aw_hs  = r_awvalid & M_AXI_AWREADY;
   assign w_w_hs   = r_wvalid & M_AXI_WREADY;
   // A channel is finished once its VALID has dropped or it handshakes now.
   assign w_aw_fin = ~r_awvalid | M_AXI_AWREADY;
   assign w_w_fin  = ~r_wvalid | M_AXI_WREADY;

   // Held low while reset is asserted so no command is taken during reset.
   assign cmd_ready = (r_state == ST_IDLE) && !M_AXI_ARESET;

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= RESP_OKAY;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  r_addr  <= cmd_addr;
                  r_wdata <= cmd_wdata;
                  r_wstrb <= cmd_wstrb;
                  if (cmd_write) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= ST_WR_REQ;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= ST_RD_REQ;
                  end
               end
            end
            ST_WR_REQ: begin
               if (w_aw_hs) begin
                  r_awvalid <= 1'b0;
               end
               if (w_w_hs) begin
                  r_wvalid <= 1'b0;
               end
               if (w_aw_fin && w_w_fin) begin
                  r_bready <= 1'b1;
                  r_state  <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (M_AXI_BVALID) begin
                  r_bready    <= 1'b0;
                  r_rsp_resp  <= M_AXI_BRESP;
                  r_rsp_rdata <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RSP;
               end
            end
            ST_RD_REQ: begin
               if (M_AXI_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (M_AXI_RVALID) begin
                  r_rready    <= 1'b0;
                  r_rsp_resp  <= M_AXI_RRESP;
                  r_rsp_rdata <= M_AXI_RDATA;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef DATA_READ_AXI_MASTER_TIMEOUT_EN
   data_read_axi_master_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk       (M_AXI_ACLK),
      .rst       (M_AXI_ARESET),
      .i_state   (r_state),
      .o_timeout (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   assign timeout_err   = w_timeout;

   assign M_AXI_AWADDR  = r_addr;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = r_wstrb;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARADDR  = r_addr;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = r_rready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;

endmodule
`default_nettype wire

// File: tb/tb_data_read_axi_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_data_read_axi_master
// Purpose  : Directed self-checking bench for data_read_axi_master with a
//            small behavioural AXI4-Lite slave (DATA_READ_AXI_MASTER_TIMEOUT_EN aware).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_data_read_axi_master;

`ifdef DATA_READ_AXI_MASTER_TIMEOUT_EN
   localparam logic c_TO_EXP = 1'b1;
`else
   localparam logic c_TO_EXP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, timeout_err;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   data_read_axi_master #(
      .ADDR_W (32), .DATA_W (32), .TIMEOUT (16)
   ) dut (
      .M_AXI_ACLK (clk), .M_AXI_ARESET (rst),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
      .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata), .rsp_resp (rsp_resp),
      .M_AXI_AWADDR (awaddr), .M_AXI_AWVALID (awvalid), .M_AXI_AWREADY (awready),
      .M_AXI_WDATA (wdata), .M_AXI_WSTRB (wstrb), .M_AXI_WVALID (wvalid), .M_AXI_WREADY (wready),
      .M_AXI_BRESP (bresp), .M_AXI_BVALID (bvalid), .M_AXI_BREADY (bready),
      .M_AXI_ARADDR (araddr), .M_AXI_ARVALID (arvalid), .M_AXI_ARREADY (arready),
      .M_AXI_RDATA (rdata), .M_AXI_RRESP (rresp), .M_AXI_RVALID (rvalid), .M_AXI_RREADY (rready),
      .timeout_err (timeout_err)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_acc    = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural slave: updates on the falling edge, remembers which
   // handshakes will complete on the following rising edge.
   int          s_w_delay = 0;
   logic        s_ar_en   = 1'b1;
   logic [1:0]  s_bresp   = 2'b00;
   logic [31:0] s_rdata   = '0;
   logic [1:0]  s_rresp   = 2'b00;
   int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

   initial begin
      logic p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, ar_got;
      int   w_wait;
      {p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, ar_got} = '0;
      w_wait = 0;
      {awready, wready, bvalid, arready, rvalid} = '0;
      bresp = 2'b00; rresp = 2'b00; rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            {p_aw, p_w, p_b, p_ar, p_r, aw_got, w_got, ar_got} = '0;
            {awready, wready, bvalid, arready, rvalid} = '0;
            w_wait = 0;
         end else begin
            if (p_aw) begin aw_got = 1'b1; n_aw++; end
            if (p_w)  begin w_got  = 1'b1; n_w++;  end
            if (p_b)  begin bvalid = 1'b0; n_b++;  end
            if (p_ar) begin ar_got = 1'b1; n_ar++; end
            if (p_r)  begin rvalid = 1'b0; n_r++;  end
            if (aw_got && w_got) begin
               bvalid = 1'b1; bresp = s_bresp; aw_got = 1'b0; w_got = 1'b0;
            end
            if (ar_got) begin
               rvalid = 1'b1; rdata = s_rdata; rresp = s_rresp; ar_got = 1'b0;
            end
            awready = 1'b1;
            arready = s_ar_en;
            if (wvalid) begin
               wready = (w_wait >= s_w_delay);
               w_wait++;
            end else begin
               wready = 1'b0;
               w_wait = 0;
            end
         end
         p_aw = awvalid & awready;
         p_w  = wvalid & wready;
         p_b  = bvalid & bready;
         p_ar = arvalid & arready;
         p_r  = rvalid & rready;
      end
   end

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      t_acc = cyc;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input int exp_lat);
      while (!rsp_valid && (cyc - t_acc) < 60) tick();
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_latency"}, 64'(cyc - t_acc), 64'(exp_lat));
   endtask

   task automatic consume(input string tag);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_rsp_drop"}, {62'd0, rsp_valid, cmd_ready}, 64'b01);
   endtask

   initial begin
      int bad, aw_c, wv_c;
      rst = 1'b1; rsp_ready = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      tick(); tick();
      check("rst_valids", {58'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 64'd0);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_rsp_data", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
      check("rst_timeout", 64'(timeout_err), 64'd0);
      rst = 1'b0;
      tick();
      check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

      // Write, slave always ready
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      check("wr1_req", {cmd_ready, awvalid, wvalid, awaddr, wstrb}, {1'b0, 1'b1, 1'b1, 32'h10, 4'hF});
      check("wr1_wdata", 64'(wdata), 64'hDEADBEEF);
      tick();
      check("wr1_after_hs", {61'd0, awvalid, wvalid, bready}, 64'b001);
      wait_rsp("wr1", 3);
      check("wr1_resp", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
      consume("wr1");

      // Write with WREADY four cycles behind AWREADY, DECERR reply
      s_w_delay = 4; s_bresp = 2'b11;
      issue(1'b1, 32'h20, 32'hA5A5_0001, 4'h3);
      aw_c = 0; wv_c = 0;
      while (!rsp_valid && (cyc - t_acc) < 60) begin
         aw_c += int'(awvalid);
         wv_c += int'(wvalid);
         tick();
      end
      check("wr2_awvalid_cycles", 64'(aw_c), 64'd1);
      check("wr2_wvalid_cycles", 64'(wv_c), 64'd5);
      wait_rsp("wr2", 7);
      check("wr2_resp", 64'(rsp_resp), 64'd3);
      consume("wr2");
      s_w_delay = 0;

      // Read with SLVERR
      s_rdata = 32'h12345678; s_rresp = 2'b10;
      issue(1'b0, 32'h04, 32'h0, 4'h0);
      check("rd1_req", {arvalid, araddr, awvalid}, {1'b1, 32'h04, 1'b0});
      wait_rsp("rd1", 3);
      check("rd1_data", {30'd0, rsp_resp, rsp_rdata}, {30'd0, 2'b10, 32'h12345678});

      // Response back-pressure with a second command pending
      s_rdata = 32'hCAFEF00D; s_rresp = 2'b00;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h08;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_resp !== 2'b10 ||
             cmd_ready !== 1'b0 || arvalid !== 1'b0) bad++;
      end
      check("stall_stable", 64'(bad), 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("stall_release", {61'd0, rsp_valid, cmd_ready, arvalid}, 64'b010);
      t_acc = cyc;
      tick();
      cmd_valid = 1'b0;
      check("rd2_req", {arvalid, araddr}, {1'b1, 32'h08});
      wait_rsp("rd2", 3);
      check("rd2_data", 64'(rsp_rdata), 64'hCAFEF00D);
      consume("rd2");

      // Read stalled on ARREADY: watchdog, then reset mid-transaction
      s_ar_en = 1'b0;
      tick();
      issue(1'b0, 32'h0C, 32'h0, 4'h0);
      while ((cyc - t_acc) < 16) tick();
      check("to_before", 64'(timeout_err), 64'd0);
      tick();
      check("to_set", {62'd0, timeout_err, arvalid}, {62'd0, c_TO_EXP, 1'b1});
      while ((cyc - t_acc) < 20) tick();
      check("to_sticky", {62'd0, timeout_err, arvalid}, {62'd0, c_TO_EXP, 1'b1});
      rst = 1'b1;
      #1;
      check("midrst_async", {62'd0, arvalid, cmd_ready}, 64'd0);
      tick();
      check("midrst_timeout_clr", 64'(timeout_err), 64'd0);
      rst = 1'b0; s_ar_en = 1'b1;
      s_rdata = 32'h0BADCAFE; s_rresp = 2'b00;
      tick();
      check("postrst_cmd_ready", 64'(cmd_ready), 64'd1);
      issue(1'b0, 32'h18, 32'h0, 4'h0);
      check("rd3_req", {arvalid, araddr}, {1'b1, 32'h18});
      wait_rsp("rd3", 3);
      check("rd3_data", {30'd0, rsp_resp, rsp_rdata}, {30'd0, 2'b00, 32'h0BADCAFE});
      consume("rd3");

      tick(); tick();
      #1;
      check("hs_counts", {n_aw[7:0], n_w[7:0], n_b[7:0], n_ar[7:0], n_r[7:0]},
            {8'd2, 8'd2, 8'd2, 8'd3, 8'd3});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire
